// File: rtl/motor3_commutation_seq_if.sv
// Operator controls and phase-driver commands of the six-step commutation sequencer.
// The master side drives the controls; the slave side is the sequencer.
interface motor3_commutation_seq_if;
  logic       m3startI;
  logic       m3forceStopI;
  logic       m3invRotateI;
  logic       m3freqINCi;
  logic       m3freqDECi;
  logic       m3powerINCi;
  logic       m3powerDECi;
  logic [1:0] aDU2o;
  logic [1:0] bDU2o;
  logic [1:0] cDU2o;
  logic [2:0] stepO;
  logic       runningO;
  logic [9:0] freqO;
  logic [3:0] powerO;

  modport master (
    output m3startI, m3forceStopI, m3invRotateI,
    output m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
    input  aDU2o, bDU2o, cDU2o, stepO, runningO, freqO, powerO
  );

  modport slave (
    input  m3startI, m3forceStopI, m3invRotateI,
    input  m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
    output aDU2o, bDU2o, cDU2o, stepO, runningO, freqO, powerO
  );
endinterface

// File: rtl/motor3_commutation_seq.sv
// Six-step commutation sequencer: a phase accumulator paces the electrical steps,
// and a free-running PWM counter gates the high-side driver of the active step.
module motor3_commutation_seq #(
  parameter int CLK_HZ    = 1000000,
  parameter int FREQ_MIN  = 1,
  parameter int FREQ_MAX  = 1000,
  parameter int FREQ_INIT = 10,
  parameter int PWR_MAX   = 15,
  parameter int PWR_INIT  = 4
) (
  input  logic                     clkI,
  input  logic                     rstI,
  motor3_commutation_seq_if.slave  bus
);
  localparam int ACC_W = $clog2(CLK_HZ + 6 * FREQ_MAX);
  localparam logic [ACC_W-1:0] CLK_VAL = ACC_W'(CLK_HZ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       step_reg, step_next;
  logic [ACC_W-1:0] acc_reg, acc_next, acc_sum;
  logic [3:0]       pwm_cnt_reg;
  logic [9:0]       freq_reg;
  logic [3:0]       power_reg;
  logic [3:0]       cur_reg, prev_reg;
  logic [3:0]       edge_hit;
  logic [1:0]       high_idx, low_idx;
  logic             pwm_on;

  // Bit order of the edge vectors: freq INC, freq DEC, power INC, power DEC.
  assign edge_hit = cur_reg & ~prev_reg;

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      cur_reg   <= '0;
      prev_reg  <= '0;
      freq_reg  <= 10'(FREQ_INIT);
      power_reg <= 4'(PWR_INIT);
    end else begin
      cur_reg  <= {bus.m3powerDECi, bus.m3powerINCi, bus.m3freqDECi, bus.m3freqINCi};
      prev_reg <= cur_reg;
      if (edge_hit[0] && !edge_hit[1] && (freq_reg < 10'(FREQ_MAX)))
        freq_reg <= freq_reg + 10'd1;
      else if (edge_hit[1] && !edge_hit[0] && (freq_reg > 10'(FREQ_MIN)))
        freq_reg <= freq_reg - 10'd1;
      if (edge_hit[2] && !edge_hit[3] && (power_reg < 4'(PWR_MAX)))
        power_reg <= power_reg + 4'd1;
      else if (edge_hit[3] && !edge_hit[2] && (power_reg > 4'd0))
        power_reg <= power_reg - 4'd1;
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI)
      pwm_cnt_reg <= '0;
    else if (pwm_cnt_reg == 4'(PWR_MAX))
      pwm_cnt_reg <= '0;
    else
      pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
  end

  assign pwm_on = (pwm_cnt_reg < power_reg);

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    acc_next   = acc_reg;
    acc_sum    = acc_reg + ACC_W'(freq_reg) * ACC_W'(6);
    case (state_reg)
      IDLE: begin
        if (bus.m3forceStopI) begin
          state_next = BRAKE;
        end else if (bus.m3startI) begin
          state_next = RUN;
          acc_next   = '0;
          step_next  = 3'd0;
        end
      end
      RUN: begin
        if (bus.m3forceStopI) begin
          state_next = BRAKE;
        end else if (!bus.m3startI) begin
          state_next = IDLE;
        end else if (acc_sum >= CLK_VAL) begin
          // Keep the remainder so the long-run step rate is exactly 6*freq.
          acc_next = acc_sum - CLK_VAL;
          if (bus.m3invRotateI)
            step_next = (step_reg == 3'd0) ? 3'd5 : step_reg - 3'd1;
          else
            step_next = (step_reg == 3'd5) ? 3'd0 : step_reg + 3'd1;
        end else begin
          acc_next = acc_sum;
        end
      end
      BRAKE: begin
        if (!bus.m3forceStopI)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Phase indices 0/1/2 = A/B/C for the high-side and low-side driver of each step.
  always_comb begin
    high_idx = 2'd0;
    low_idx  = 2'd1;
    case (step_reg)
      3'd0: begin high_idx = 2'd0; low_idx = 2'd1; end
      3'd1: begin high_idx = 2'd0; low_idx = 2'd2; end
      3'd2: begin high_idx = 2'd1; low_idx = 2'd2; end
      3'd3: begin high_idx = 2'd1; low_idx = 2'd0; end
      3'd4: begin high_idx = 2'd2; low_idx = 2'd0; end
      3'd5: begin high_idx = 2'd2; low_idx = 2'd1; end
      default: begin high_idx = 2'd0; low_idx = 2'd1; end
    endcase
  end

  // Each command is chosen from a single role, so code 3 cannot be produced.
  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    logic [1:0] cmd_next, cmd_reg;

    always_comb begin
      cmd_next = 2'd0;
      case (state_reg)
        RUN: begin
          if (high_idx == 2'(gi))
            cmd_next = pwm_on ? 2'd2 : 2'd0;
          else if (low_idx == 2'(gi))
            cmd_next = 2'd1;
        end
        BRAKE:   cmd_next = 2'd1;
        default: cmd_next = 2'd0;
      endcase
    end

    always_ff @(posedge clkI or posedge rstI) begin
      if (rstI)
        cmd_reg <= 2'd0;
      else
        cmd_reg <= cmd_next;
    end
  end

  assign bus.aDU2o    = g_phase[0].cmd_reg;
  assign bus.bDU2o    = g_phase[1].cmd_reg;
  assign bus.cDU2o    = g_phase[2].cmd_reg;
  assign bus.stepO    = step_reg;
  assign bus.runningO = (state_reg == RUN);
  assign bus.freqO    = freq_reg;
  assign bus.powerO   = power_reg;
endmodule

// File: tb/tb_motor3_commutation_seq.sv
// Bench for the commutation sequencer: step-table vectors, scoreboarded step timing,
// PWM duty counting, saturation, brake/resume and asynchronous reset.
module tb_motor3_commutation_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  motor3_commutation_seq_if m ();
  motor3_commutation_seq_if m2 ();

  motor3_commutation_seq #(
    .CLK_HZ(600), .FREQ_MIN(1), .FREQ_MAX(1000), .FREQ_INIT(1), .PWR_MAX(15), .PWR_INIT(15)
  ) dut (
    .clkI(clk), .rstI(rst), .bus(m)
  );

  motor3_commutation_seq #(
    .CLK_HZ(600), .FREQ_MIN(1), .FREQ_MAX(1000), .FREQ_INIT(999), .PWR_MAX(15), .PWR_INIT(15)
  ) dut2 (
    .clkI(clk), .rstI(rst), .bus(m2)
  );

  typedef struct {
    logic [2:0] step;
    int         period;   // -1: not timed
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0] step;
    logic [1:0] a, b, c;  // 2 = gated high side, 1 = low side, 0 = float
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
      $display("check %s: got %0d expected %0d ok", name, actual, expected);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Code 3 would short a half-bridge; watch every cycle on both instances.
  always @(negedge clk) begin
    if (m.aDU2o == 2'd3 || m.bDU2o == 2'd3 || m.cDU2o == 2'd3 ||
        m2.aDU2o == 2'd3 || m2.bDU2o == 2'd3 || m2.cDU2o == 2'd3) begin
      n_total++;
      $display("FAIL illegal_code: got 3 expected 0..2 at %0t", $time);
    end
    assert (m.aDU2o != 2'd3 && m.bDU2o != 2'd3 && m.cDU2o != 2'd3)
      else $error("illegal phase command");
  end

  task automatic push(input logic [2:0] step, input int period);
    exp_t e;
    e.step   = step;
    e.period = period;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    int         cnt;
    logic [2:0] prev;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      cnt  = 0;
      prev = m.stepO;
      while (m.stepO == prev && cnt < 400) begin
        @(negedge clk);
        cnt++;
      end
      if (m.stepO == prev) begin
        check("step_timeout", cnt, -1);
      end else begin
        check("step_value", m.stepO, e.step);
        if (e.period >= 0) check("step_period", cnt, e.period);
      end
    end
  endtask

  task automatic pulse(input int sel);
    case (sel)
      0: m.m3freqINCi = 1'b1;
      1: m.m3freqDECi = 1'b1;
      2: m.m3powerINCi = 1'b1;
      3: m.m3powerDECi = 1'b1;
      4: begin m.m3powerINCi = 1'b1; m.m3powerDECi = 1'b1; end
      default: m2.m3freqINCi = 1'b1;
    endcase
    @(negedge clk);
    m.m3freqINCi  = 1'b0;
    m.m3freqDECi  = 1'b0;
    m.m3powerINCi = 1'b0;
    m.m3powerDECi = 1'b0;
    m2.m3freqINCi = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic count_window(output int highs, output int lows);
    highs = 0;
    lows  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m.aDU2o == 2'd2 || m.bDU2o == 2'd2 || m.cDU2o == 2'd2) highs++;
      if (int'(m.aDU2o == 2'd1) + int'(m.bDU2o == 2'd1) + int'(m.cDU2o == 2'd1) == 1) lows++;
    end
  endtask

  initial begin
    int highs, lows, bad, waited;

    vecs[0] = '{3'd0, 2'd2, 2'd1, 2'd0};
    vecs[1] = '{3'd1, 2'd2, 2'd0, 2'd1};
    vecs[2] = '{3'd2, 2'd0, 2'd2, 2'd1};
    vecs[3] = '{3'd3, 2'd1, 2'd2, 2'd0};
    vecs[4] = '{3'd4, 2'd1, 2'd0, 2'd2};
    vecs[5] = '{3'd5, 2'd0, 2'd1, 2'd2};

    m.m3startI = 1'b0; m.m3forceStopI = 1'b0; m.m3invRotateI = 1'b0;
    m.m3freqINCi = 1'b0; m.m3freqDECi = 1'b0; m.m3powerINCi = 1'b0; m.m3powerDECi = 1'b0;
    m2.m3startI = 1'b0; m2.m3forceStopI = 1'b0; m2.m3invRotateI = 1'b0;
    m2.m3freqINCi = 1'b0; m2.m3freqDECi = 1'b0; m2.m3powerINCi = 1'b0; m2.m3powerDECi = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_step", m.stepO, 0);
    check("rst_running", m.runningO, 0);
    check("rst_freq", m.freqO, 1);
    check("rst_power", m.powerO, 15);
    check("rst_phases", {m.aDU2o, m.bDU2o, m.cDU2o}, 0);
    check("rst_freq2", m2.freqO, 999);
    rst = 1'b0;
    @(negedge clk);

    // Upper frequency saturation on the second instance.
    pulse(5);
    check("freq_inc_to_max", m2.freqO, 1000);
    pulse(5);
    pulse(5);
    check("freq_sat_max", m2.freqO, 1000);

    // Forward rotation at 1 Hz: 6 steps/s at 600 Hz clock = 100 cycles per step.
    m.m3startI = 1'b1;
    @(negedge clk);
    check("run_entry", m.runningO, 1);
    check("run_entry_step", m.stepO, 0);
    push(3'd1, 100); push(3'd2, 100); push(3'd3, 100);
    push(3'd4, 100); push(3'd5, 100); push(3'd0, 100);
    drain();

    // Step table: low/float fixed, high side on 15 of 16 cycles at full power.
    for (int r = 0; r < 6; r++) begin
      waited = 0;
      while (m.stepO != vecs[r].step && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      repeat (2) @(negedge clk);
      highs = 0;
      bad   = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (m.aDU2o == 2'd2 || m.bDU2o == 2'd2 || m.cDU2o == 2'd2) highs++;
        if ((vecs[r].a == 2'd2 ? (m.aDU2o != 2'd2 && m.aDU2o != 2'd0) : (m.aDU2o != vecs[r].a)) ||
            (vecs[r].b == 2'd2 ? (m.bDU2o != 2'd2 && m.bDU2o != 2'd0) : (m.bDU2o != vecs[r].b)) ||
            (vecs[r].c == 2'd2 ? (m.cDU2o != 2'd2 && m.cDU2o != 2'd0) : (m.cDU2o != vecs[r].c)))
          bad++;
      end
      check($sformatf("table%0d_roles", r), bad, 0);
      check($sformatf("table%0d_high_cycles", r), highs, 15);
    end

    // Reverse rotation from step 5, then switch back mid-step.
    m.m3invRotateI = 1'b1;
    push(3'd4, -1); push(3'd3, 100); push(3'd2, 100); push(3'd1, 100); push(3'd0, 100);
    drain();
    repeat (50) @(negedge clk);
    m.m3invRotateI = 1'b0;
    push(3'd1, -1); push(3'd2, 100);
    drain();

    // Duty: down to 0 (one extra pulse saturates), then up to 3.
    for (int i = 0; i < 16; i++) pulse(3);
    check("power_sat_min", m.powerO, 0);
    count_window(highs, lows);
    check("power0_high_cycles", highs, 0);
    check("power0_low_cycles", lows, 16);
    for (int i = 0; i < 3; i++) pulse(2);
    check("power_inc3", m.powerO, 3);
    count_window(highs, lows);
    check("power3_high_cycles", highs, 3);
    check("power3_low_cycles", lows, 16);
    pulse(4);
    check("power_inc_dec_same", m.powerO, 3);

    // Stop, adjust frequency, restart at 2 Hz: 50 cycles per step.
    m.m3startI = 1'b0;
    @(negedge clk);
    check("stop_running", m.runningO, 0);
    @(negedge clk);
    check("stop_phases", {m.aDU2o, m.bDU2o, m.cDU2o}, 0);
    pulse(1);
    check("freq_sat_min", m.freqO, 1);
    pulse(0);
    check("freq_inc", m.freqO, 2);
    m.m3startI = 1'b1;
    @(negedge clk);
    check("restart_running", m.runningO, 1);
    check("restart_step", m.stepO, 0);
    push(3'd1, 50); push(3'd2, 50); push(3'd3, 50);
    push(3'd4, 50); push(3'd5, 50); push(3'd0, 50);
    drain();

    // Force-stop mid-run, then release with start still high.
    m.m3forceStopI = 1'b1;
    @(negedge clk);
    check("brake_running", m.runningO, 0);
    check("brake_step_held", m.stepO, 0);
    @(negedge clk);
    check("brake_phases", {m.aDU2o, m.bDU2o, m.cDU2o}, 6'b010101);
    repeat (5) @(negedge clk);
    check("brake_hold", {m.aDU2o, m.bDU2o, m.cDU2o}, 6'b010101);
    m.m3forceStopI = 1'b0;
    @(negedge clk);
    check("release_idle_running", m.runningO, 0);
    @(negedge clk);
    check("release_idle_phases", {m.aDU2o, m.bDU2o, m.cDU2o}, 0);
    check("resume_running", m.runningO, 1);
    @(negedge clk);
    check("resume_step", m.stepO, 0);
    check("resume_low_b", m.bDU2o, 1);
    check("resume_float_c", m.cDU2o, 0);

    // Asynchronous reset between clock edges.
    repeat (37) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_step", m.stepO, 0);
    check("arst_running", m.runningO, 0);
    check("arst_phases", {m.aDU2o, m.bDU2o, m.cDU2o}, 0);
    check("arst_freq", m.freqO, 1);
    check("arst_power", m.powerO, 15);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
